axis_ask_uart_rx: RTL and testbench
===================================

Name: axis_ask_uart_rx

Overview:
Receive-side counterpart of the ASK UART transmitter wrapper. It takes the 2-bit ASK level from the wing comparator pins, resynchronises it, and maps it to a UART line bit. It then deframes 8N1 characters by oversampling with a clock divider and presents each received byte on an AXI-Stream master through a small FWFT FIFO. It sits beside axis_uart_rx_wrapper in loopback/bridge tops, with the same clk/rst domain and the same RX_SIZE/clkdiv_rx parameter semantics.

Parameters:
RX_SIZE, 4, FIFO address width; depth = 2**RX_SIZE bytes
clkdiv_rx, 100, clk cycles per bit; legal range >= 4
sync_stages, 2, synchroniser flops on ask_rx; legal range >= 2

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
ask_rx  in  2  ASK level: 2'b11 mark ('1'), 2'b01 space ('0'), 2'b00 or 2'b10 no carrier
o_tdata  out  8  received byte, LSB first on the line
o_tvalid  out  1  AXIS valid
o_tready  in  1  AXIS ready
frame_err  out  1  one-cycle pulse: stop bit sampled as space
carrier_err  out  1  one-cycle pulse: no-carrier symbol seen at any sample point inside a frame
overflow  out  1  one-cycle pulse: good byte dropped because FIFO full
busy  out  1  high while FSM is not in IDLE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, counters=0, FIFO empty. o_tvalid=0, o_tdata=0, all pulse outputs=0, busy=0. Synchroniser flops reset to mark (2'b11).
- Line bit = 1 for 11, 0 for 01. Carrier-valid = symbol is 11 or 01. Decoding uses the last synchroniser stage only.
- FSM states:
  - IDLE: on line bit 0 with valid carrier -> START; bit counter cleared; tick counter loaded with clkdiv_rx/2-1 (integer division).
  - START: at tick expiry, resample. Space -> DATA, with tick counter reloaded to clkdiv_rx-1. Mark -> IDLE as a glitch, with no flag. No carrier -> carrier_err, then WAIT_IDLE.
  - DATA: at each tick expiry, shift the bit into bit 7 of the shift register (shift right). After 8 bits -> STOP. No carrier at any sample -> carrier_err, then WAIT_IDLE.
  - STOP: at tick expiry:
    - mark -> write shift register to FIFO (if full: drop byte, pulse overflow), then IDLE;
    - space -> frame_err, byte discarded, WAIT_IDLE;
    - no carrier -> carrier_err, WAIT_IDLE.
  - WAIT_IDLE: stay until a valid mark is sampled, then IDLE. This prevents resync inside a break or a dead carrier.
- Sample points: mid-bit, i.e. clkdiv_rx/2 cycles after the synchronised falling edge, then every clkdiv_rx cycles.
- Latency: the FIFO write happens in the stop-sample cycle; o_tvalid/o_tdata are valid on the next clk edge.
- AXIS rules: a transfer occurs on o_tvalid & o_tready. o_tdata is stable while o_tvalid=1 and o_tready=0. o_tvalid is independent of o_tready.
- FIFO boundaries:
  - Simultaneous write and read when full: read frees a slot in the same cycle, so the write succeeds and no overflow is flagged.
  - Simultaneous write and read when empty: the new byte appears next cycle.
  - Pointers are RX_SIZE+1 bits and wrap naturally.
- Reset mid-frame: the partial byte is lost and the FIFO is flushed. No error pulse is generated on the reset edge.
- Error pulses are mutually exclusive within a cycle and never fire in IDLE.

Decomposition:
- Package ask_uart_pkg holds:
  - localparams ASK_MARK=2'b11, ASK_SPACE=2'b01, ASK_OFF=2'b00;
  - the FSM state encoding (IDLE, START, DATA, STOP, WAIT_IDLE);
  - UART_DATA_BITS=8.
- The TX wrapper should import the same symbol constants.
- One sub-module, axis_fifo_fwft (params ADDR_W, DATA_W), holds the storage, full/empty and the AXIS output side. The deframer FSM stays in the top of the block.

Test Plan:
- clkdiv_rx=8. Send 0xA5 as 8N1 ASK symbols, o_tready=1 -> o_tvalid for 1 cycle with o_tdata=0xA5. The pulse arrives 2 sync cycles + 4 + 9*8 cycles + 1 cycle after the first space symbol.
- Space glitch of 3 cycles while IDLE -> FSM returns to IDLE, no FIFO write, no error pulses.
- Send 0x3C with the stop bit forced to space, then hold mark -> frame_err single pulse, FIFO empty. A following 0x81 is received correctly.
- Drive ASK_OFF for 1 bit time during data bit 4 of 0xFF -> carrier_err pulse, no write, busy stays high until mark is restored.
- RX_SIZE=2, o_tready=0, send 5 bytes 0x01..0x05 -> FIFO holds 0x01..0x04 and overflow pulses once. Release o_tready -> 0x01,0x02,0x03,0x04 in order, then o_tvalid=0.
- Assert rst during data bit 3 of 0x55 -> all outputs return to reset values immediately. After release, 0x66 is received correctly.

Source files
------------

// File: rtl/ask_uart_pkg.sv
// Shared ASK UART definitions: line symbols, frame width, receiver FSM states
// and the symbol decoder used by both the RX deframer and the TX wrapper.
package ask_uart_pkg;

   // ASK comparator levels on the wing pins (2'b10 is also no carrier)
   localparam logic [1:0] ASK_MARK  = 2'b11;
   localparam logic [1:0] ASK_SPACE = 2'b01;
   localparam logic [1:0] ASK_OFF   = 2'b00;

   localparam int unsigned UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   // Decoded line symbol: carrier present, and the UART bit it carries
   typedef struct packed {
      logic carrier;
      logic mark;
   } ask_sym_t;

   function automatic ask_sym_t ask_decode(input logic [1:0] sym);
      ask_sym_t d;
      d.carrier = (sym == ASK_MARK) || (sym == ASK_SPACE);
      d.mark    = (sym == ASK_MARK);
      return d;
   endfunction

endpackage

// File: rtl/axis_ask_uart_rx_if.sv
// AXI-Stream byte channel carrying received UART characters.
//   tdata  : received byte
//   tvalid : byte available
//   tready : consumer accepts the byte
interface axis_ask_uart_rx_if
   import ask_uart_pkg::*;
   ();

   logic [UART_DATA_BITS-1:0] tdata;
   logic                      tvalid;
   logic                      tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_fifo_fwft.sv
// First-word-fall-through FIFO with a registered AXI-Stream read side.
//   clk, rst          : clock, async active-high reset
//   wr_req, wr_data   : write request and byte (dropped when full and not read)
//   tdata/tvalid/tready : AXIS output, tdata held while tvalid & !tready
//   overflow          : one-cycle pulse when a write is dropped
module axis_fifo_fwft #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] tdata,
   output logic              tvalid,
   input  logic              tready,
   output logic              overflow
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned PTR_W = ADDR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W-1:0]  wr_next_c, rd_next_c;
   logic              full_c, rd_fire_c, wr_en_c, valid_next_c;
   logic [DATA_W-1:0] head_next_c;

   // Pointer arithmetic; a read in the same cycle frees a slot for a write when full
   always_comb begin
      full_c       = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
      rd_fire_c    = tvalid && tready;
      wr_en_c      = wr_req && (!full_c || rd_fire_c);
      rd_next_c    = rd_ptr + PTR_W'(rd_fire_c);
      wr_next_c    = wr_ptr + PTR_W'(wr_en_c);
      valid_next_c = (wr_next_c != rd_next_c);
      // Bypass when the byte being written becomes the next head
      if (wr_en_c && (wr_ptr[ADDR_W-1:0] == rd_next_c[ADDR_W-1:0]))
         head_next_c = wr_data;
      else
         head_next_c = mem[rd_next_c[ADDR_W-1:0]];
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (wr_en_c)
         mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
   end

   // Pointers and registered output side
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tvalid   <= 1'b0;
         tdata    <= '0;
         overflow <= 1'b0;
      end else begin
         wr_ptr   <= wr_next_c;
         rd_ptr   <= rd_next_c;
         tvalid   <= valid_next_c;
         if (valid_next_c)
            tdata <= head_next_c;
         overflow <= wr_req && !wr_en_c;
      end
   end

endmodule

// File: rtl/axis_ask_uart_rx.sv
// ASK UART receiver: resynchronises the 2-bit ASK level, deframes 8N1
// characters by mid-bit sampling and queues bytes in a FWFT FIFO.
//   clk, rst    : clock, async active-high reset
//   ask_rx      : ASK level (11 mark, 01 space, 00/10 no carrier)
//   axis        : AXIS master carrying received bytes
//   frame_err   : pulse, stop bit sampled as space
//   carrier_err : pulse, no carrier at a sample point inside a frame
//   overflow    : pulse, good byte dropped because the FIFO was full
//   busy        : deframer not idle
module axis_ask_uart_rx
   import ask_uart_pkg::*;
#(
   parameter int unsigned RX_SIZE     = 4,
   parameter int unsigned clkdiv_rx   = 100,
   parameter int unsigned sync_stages = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                ask_rx,
   axis_ask_uart_rx_if.master        axis,
   output logic                      frame_err,
   output logic                      carrier_err,
   output logic                      overflow,
   output logic                      busy
);

   localparam int unsigned TICK_W = $clog2(clkdiv_rx);
   localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
   localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(clkdiv_rx - 1);
   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(clkdiv_rx / 2 - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

   logic [1:0]                sync_q [sync_stages];
   ask_sym_t                  sym_c;
   rx_state_t                 state;
   logic [TICK_W-1:0]         tick;
   logic [BIT_W-1:0]          bit_cnt;
   logic [UART_DATA_BITS-1:0] shift;
   logic                      wr_c;

   // Resynchroniser; idles at mark so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(sync_stages); i++)
            sync_q[i] <= ASK_MARK;
      end else begin
         sync_q[0] <= ask_rx;
         for (int i = 1; i < int'(sync_stages); i++)
            sync_q[i] <= sync_q[i-1];
      end
   end

   assign sym_c = ask_decode(sync_q[sync_stages-1]);

   // Good stop bit writes the byte in the stop-sample cycle
   assign wr_c = (state == STOP) && (tick == '0) && sym_c.carrier && sym_c.mark;

   // Deframer FSM; tick counts down to the next mid-bit sample point
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         tick        <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         frame_err   <= 1'b0;
         carrier_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         frame_err   <= 1'b0;
         carrier_err <= 1'b0;
         case (state)
            IDLE: begin
               if (sym_c.carrier && !sym_c.mark) begin
                  state   <= START;
                  busy    <= 1'b1;
                  tick    <= TICK_HALF;
                  bit_cnt <= '0;
               end
            end
            START: begin
               if (tick != '0) begin
                  tick <= tick - TICK_W'(1);
               end else begin
                  tick <= TICK_FULL;
                  if (!sym_c.carrier) begin
                     carrier_err <= 1'b1;
                     state       <= WAIT_IDLE;
                  end else if (sym_c.mark) begin
                     // Start bit did not hold to mid-bit: treat as a glitch
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (tick != '0) begin
                  tick <= tick - TICK_W'(1);
               end else begin
                  tick <= TICK_FULL;
                  if (!sym_c.carrier) begin
                     carrier_err <= 1'b1;
                     state       <= WAIT_IDLE;
                  end else begin
                     shift   <= {sym_c.mark, shift[UART_DATA_BITS-1:1]};
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     if (bit_cnt == BIT_LAST)
                        state <= STOP;
                  end
               end
            end
            STOP: begin
               if (tick != '0) begin
                  tick <= tick - TICK_W'(1);
               end else if (!sym_c.carrier) begin
                  carrier_err <= 1'b1;
                  state       <= WAIT_IDLE;
               end else if (sym_c.mark) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  frame_err <= 1'b1;
                  state     <= WAIT_IDLE;
               end
            end
            WAIT_IDLE: begin
               // Hold off resync through a break or dead carrier
               if (sym_c.carrier && sym_c.mark) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   axis_fifo_fwft #(
      .ADDR_W (RX_SIZE),
      .DATA_W (UART_DATA_BITS)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_req   (wr_c),
      .wr_data  (shift),
      .tdata    (axis.tdata),
      .tvalid   (axis.tvalid),
      .tready   (axis.tready),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_axis_ask_uart_rx.sv
// Testbench for axis_ask_uart_rx: drives ASK symbol frames cycle by cycle and
// compares received bytes, error pulses and timing against a frame-level model.
module tb_axis_ask_uart_rx;
   import ask_uart_pkg::*;

   localparam int unsigned CLKDIV  = 8;
   localparam int unsigned RX_SIZE = 2;
   localparam int unsigned DEPTH   = 1 << RX_SIZE;
   localparam int unsigned SYNC    = 2;
   localparam int unsigned LATENCY = SYNC + CLKDIV / 2 + 9 * CLKDIV + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] ask_rx;
   logic       frame_err, carrier_err, overflow, busy;

   axis_ask_uart_rx_if axis ();

   axis_ask_uart_rx #(
      .RX_SIZE     (RX_SIZE),
      .clkdiv_rx   (CLKDIV),
      .sync_stages (SYNC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ask_rx      (ask_rx),
      .axis        (axis),
      .frame_err   (frame_err),
      .carrier_err (carrier_err),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int fe_cnt = 0, ce_cnt = 0, ov_cnt = 0;
   int exp_fe = 0, exp_ce = 0, exp_ov = 0;
   int pop_cnt = 0;
   int last_pop_cyc = -1;
   int start_cyc;
   int pulses;
   int pops_before;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor: sampled mid-cycle, between input changes and the next edge
   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         pulses = int'(frame_err) + int'(carrier_err) + int'(overflow);
         if (pulses > 1)
            check("pulse_exclusive", 32'(pulses), 32'd1);
         if (frame_err)   fe_cnt++;
         if (carrier_err) ce_cnt++;
         if (overflow)    ov_cnt++;
         if (prev_stall) begin
            check("hold_valid", 32'(axis.tvalid), 32'd1);
            check("hold_data", 32'(axis.tdata), 32'(prev_data));
         end
         if (axis.tvalid && axis.tready) begin
            if (exp_q.size() == 0)
               check("extra_byte", 32'(exp_q.size()), 32'd1);
            else
               check("rx_byte", 32'(axis.tdata), 32'(exp_q.pop_front()));
            pop_cnt++;
            last_pop_cyc = cyc;
         end
         prev_stall = axis.tvalid && !axis.tready;
         prev_data  = axis.tdata;
      end
   end

   task automatic send_sym(input logic [1:0] s, input int n);
      ask_rx = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      send_sym(ASK_MARK, n);
   endtask

   // 8N1 frame; drop_bit >= 0 replaces that data bit with no carrier and the rest with mark
   task automatic send_frame(input logic [7:0] d, input logic stop_mark, input int drop_bit);
      logic [1:0] s;
      send_sym(ASK_SPACE, CLKDIV);
      for (int i = 0; i < 8; i++) begin
         if (i == drop_bit)
            s = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
         else if (drop_bit >= 0 && i > drop_bit)
            s = ASK_MARK;
         else
            s = d[i] ? ASK_MARK : ASK_SPACE;
         send_sym(s, CLKDIV);
      end
      send_sym(stop_mark ? ASK_MARK : ASK_SPACE, CLKDIV);
   endtask

   // Model: a good frame lands in the FIFO unless it already holds DEPTH unread bytes
   task automatic model_good(input logic [7:0] d);
      if (exp_q.size() >= int'(DEPTH))
         exp_ov++;
      else
         exp_q.push_back(d);
   endtask

   task automatic tx_good(input logic [7:0] d);
      model_good(d);
      send_frame(d, 1'b1, -1);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_frame_err"}, 32'(fe_cnt), 32'(exp_fe));
      check({tag, "_carrier_err"}, 32'(ce_cnt), 32'(exp_ce));
      check({tag, "_overflow"}, 32'(ov_cnt), 32'(exp_ov));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"}, 32'(axis.tvalid), 32'd0);
      check({tag, "_tdata"}, 32'(axis.tdata), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_pulses"}, 32'({frame_err, carrier_err, overflow}), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      ask_rx      = ASK_MARK;
      axis.tready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      idle(4);

      // Single byte and end-to-end latency
      model_good(8'hA5);
      start_cyc = cyc;
      send_frame(8'hA5, 1'b1, -1);
      idle(6);
      check("latency", 32'(last_pop_cyc - start_cyc), 32'(LATENCY));
      check("a5_popped", 32'(pop_cnt), 32'd1);
      check_counts("a5");

      // Short space glitch while idle
      send_sym(ASK_SPACE, 3);
      idle(2 * CLKDIV);
      #1;
      check("glitch_busy", 32'(busy), 32'd0);
      check("glitch_tvalid", 32'(axis.tvalid), 32'd0);
      check_counts("glitch");

      // Stop bit as space, then a clean byte
      send_frame(8'h3C, 1'b0, -1);
      exp_fe++;
      idle(2 * CLKDIV);
      #1;
      check("ferr_tvalid", 32'(axis.tvalid), 32'd0);
      check_counts("ferr");
      tx_good(8'h81);
      idle(6);
      check_counts("after_ferr");

      // Carrier drop during data bit 4 of 0xFF
      send_sym(ASK_SPACE, CLKDIV);
      send_sym(ASK_MARK, 4 * CLKDIV);
      send_sym(ASK_OFF, CLKDIV);
      exp_ce++;
      #1;
      check("drop_busy", 32'(busy), 32'd1);
      check("drop_pulse", 32'(ce_cnt), 32'(exp_ce));
      send_sym(ASK_MARK, 4 * CLKDIV);
      #1;
      check("drop_recovered_busy", 32'(busy), 32'd0);
      check("drop_tvalid", 32'(axis.tvalid), 32'd0);
      check_counts("drop");

      // Reset during data bit 3 of 0x55
      send_sym(ASK_SPACE, CLKDIV);
      send_sym(ASK_MARK, CLKDIV);
      send_sym(ASK_SPACE, CLKDIV);
      send_sym(ASK_MARK, CLKDIV);
      send_sym(ASK_SPACE, 3);
      rst = 1'b1;
      #1;
      check_reset_outputs("midframe_rst");
      exp_q.delete();
      @(negedge clk);
      ask_rx = ASK_MARK;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(4);
      tx_good(8'h66);
      idle(6);
      check_counts("after_rst");

      // Randomised frame mix
      for (int n = 0; n < 24; n++) begin
         int kind;
         logic [7:0] d;
         kind = int'($urandom_range(0, 9));
         d    = 8'($urandom_range(0, 255));
         if (kind <= 5) begin
            tx_good(d);
         end else if (kind == 6) begin
            send_frame(d, 1'b0, -1);
            exp_fe++;
         end else if (kind == 7) begin
            send_frame(d, 1'b1, int'($urandom_range(0, 7)));
            exp_ce++;
         end else begin
            send_sym(ASK_SPACE, int'($urandom_range(1, 3)));
         end
         idle(int'($urandom_range(3, 12)));
         check_counts("rand");
      end

      // Overflow with the consumer stalled
      @(negedge clk);
      axis.tready = 1'b0;
      pops_before = pop_cnt;
      for (int b = 1; b <= 5; b++) begin
         tx_good(8'(b));
         idle(4);
      end
      #1;
      check_counts("ovf");
      check("ovf_tvalid", 32'(axis.tvalid), 32'd1);
      check("ovf_head", 32'(axis.tdata), 32'h01);
      check("ovf_queued", 32'(exp_q.size()), 32'(DEPTH));
      @(negedge clk);
      axis.tready = 1'b1;
      for (int w = 0; w < 100 && exp_q.size() != 0; w++)
         @(negedge clk);
      repeat (2) @(negedge clk);
      #1;
      check("ovf_drained", 32'(pop_cnt - pops_before), 32'(DEPTH));
      check("ovf_empty_tvalid", 32'(axis.tvalid), 32'd0);
      check("final_queue", 32'(exp_q.size()), 32'd0);
      check_counts("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
